// File: rtl/craft_pkg.sv
// Shared constants, FSM encoding and the CRAFT tweak nibble permutation.
package craft_pkg;

    localparam int unsigned TK_W    = 64;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_NIB = TK_W / NIB_W;
    localparam int unsigned KEY_W   = 2 * TK_W;

    // Q(T) nibble i takes T nibble Q_PERM[i]; nibble 0 is the most significant.
    localparam int unsigned Q_PERM [NUM_NIB] = '{12, 10, 15, 5, 14, 8, 9, 2,
                                                 11, 3, 7, 4, 6, 0, 1, 13};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREP   = 2'd1,
        ST_STREAM = 2'd2
    } tk_state_t;

    function automatic logic [TK_W-1:0] q_perm(input logic [TK_W-1:0] t);
        logic [TK_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_NIB; i++) begin
            r[TK_W-1-NIB_W*i -: NIB_W] = t[TK_W-1-NIB_W*Q_PERM[i] -: NIB_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/craft_tk_prep.sv
// Combinational derivation of the four CRAFT tweakeys from key and tweak.
module craft_tk_prep
    import craft_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [TK_W-1:0]  tweak,
    output logic [TK_W-1:0]  tk0,
    output logic [TK_W-1:0]  tk1,
    output logic [TK_W-1:0]  tk2,
    output logic [TK_W-1:0]  tk3
);

    logic [TK_W-1:0] tweak_q;

    // TK0/TK1 use the raw tweak, TK2/TK3 the Q-permuted tweak.
    always_comb begin
        tweak_q = q_perm(tweak);
        tk0     = key[KEY_W-1:TK_W] ^ tweak;
        tk1     = key[TK_W-1:0]     ^ tweak;
        tk2     = key[KEY_W-1:TK_W] ^ tweak_q;
        tk3     = key[TK_W-1:0]     ^ tweak_q;
    end

endmodule

// File: rtl/craft_tk_stream.sv
// Sequential CRAFT tweakey streamer: load key/tweak once, then emit one
// round tweakey per accepted valid/ready beat in ascending or descending order.
module craft_tk_stream
    import craft_pkg::*;
#(
    parameter int NUM_ROUNDS = 32,
    parameter int ROUND_W    = 8
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [127:0]       key,
    input  logic [63:0]        tweak,
    input  logic               dec,
    input  logic               abort,
    output logic               tk_valid,
    input  logic               tk_ready,
    output logic [63:0]        tk,
    output logic [ROUND_W-1:0] tk_round,
    output logic               tk_last
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > (2 ** ROUND_W)) begin : g_bad_rounds
        $error("craft_tk_stream: NUM_ROUNDS out of range for ROUND_W");
    end

    localparam logic [ROUND_W-1:0] LAST_ENC = ROUND_W'(NUM_ROUNDS - 1);

    tk_state_t          state;
    logic [KEY_W-1:0]   key_r;
    logic [TK_W-1:0]    tweak_r;
    logic               dec_r;
    logic [TK_W-1:0]    tk0_r, tk1_r, tk2_r, tk3_r;
    logic [TK_W-1:0]    tk0_c, tk1_c, tk2_c, tk3_c;
    logic [ROUND_W-1:0] cnt;
    logic [ROUND_W-1:0] cnt_step;
    logic [ROUND_W-1:0] pres_idx;
    logic [ROUND_W-1:0] final_idx;
    logic [TK_W-1:0]    pres_tk;

    craft_tk_prep u_prep (
        .key   (key_r),
        .tweak (tweak_r),
        .tk0   (tk0_c),
        .tk1   (tk1_c),
        .tk2   (tk2_c),
        .tk3   (tk3_c)
    );

    assign load_ready = (state == ST_IDLE);

    // Index and tweakey of the beat to present next: the current counter on
    // the first STREAM cycle, otherwise the stepped counter.
    always_comb begin
        cnt_step  = dec_r ? (cnt - 1'b1) : (cnt + 1'b1);
        final_idx = dec_r ? '0 : LAST_ENC;
        pres_idx  = tk_valid ? cnt_step : cnt;
        case (pres_idx[1:0])
            2'd0:    pres_tk = tk0_r;
            2'd1:    pres_tk = tk1_r;
            2'd2:    pres_tk = tk2_r;
            default: pres_tk = tk3_r;
        endcase
    end

    // FSM, round counter and registered outputs; abort overrides everything.
    // Outputs are preloaded with the following beat on each accept so the
    // stream sustains one beat per cycle from registers.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state    <= ST_IDLE;
            key_r    <= '0;
            tweak_r  <= '0;
            dec_r    <= 1'b0;
            tk0_r    <= '0;
            tk1_r    <= '0;
            tk2_r    <= '0;
            tk3_r    <= '0;
            cnt      <= '0;
            tk_valid <= 1'b0;
            tk_last  <= 1'b0;
            tk       <= '0;
            tk_round <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            tk_valid <= 1'b0;
            tk_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_valid) begin
                        key_r   <= key;
                        tweak_r <= tweak;
                        dec_r   <= dec;
                        state   <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    tk0_r <= tk0_c;
                    tk1_r <= tk1_c;
                    tk2_r <= tk2_c;
                    tk3_r <= tk3_c;
                    cnt   <= dec_r ? LAST_ENC : '0;
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (!tk_valid) begin
                        tk       <= pres_tk;
                        tk_round <= pres_idx;
                        tk_last  <= (pres_idx == final_idx);
                        tk_valid <= 1'b1;
                    end else if (tk_ready) begin
                        if (tk_last) begin
                            tk_valid <= 1'b0;
                            tk_last  <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            cnt      <= pres_idx;
                            tk       <= pres_tk;
                            tk_round <= pres_idx;
                            tk_last  <= (pres_idx == final_idx);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
